// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I/D-cache memory arbiter.
// Holds the FSM state encoding, the requester ids and the round-robin pick helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  // Requester ids, also used as the grant / owner / err_owner encoding.
  localparam logic RqI = 1'b0;  // icache
  localparam logic RqD = 1'b1;  // dcache

  // Two-way round-robin: on a tie the requester not served last wins.
  function automatic logic rr_pick(logic ireq, logic dreq, logic last);
    if (ireq && dreq) begin
      return ~last;
    end
    return dreq;  // only icache -> RqI, only dcache -> RqD
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the requester (icache/dcache) and main-memory signals around mem_arbiter.
//   master : arbiter view (takes requests and mem response, drives acks and the mem port)
//   slave  : environment view (caches plus memory model)
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  // icache requester
  logic              i_req;
  logic              i_we;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic              i_ack;
  // dcache requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  // shared read return
  logic [DATA_W-1:0] rdata;
  // memory port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  // watchdog status
  logic              err;
  logic              err_owner;

  modport master (
    input  i_req, i_we, i_addr, i_wdata,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata, mem_ready,
    output i_ack, d_ack, rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output err, err_owner
  );

  modport slave (
    output i_req, i_we, i_addr, i_wdata,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata, mem_ready,
    input  i_ack, d_ack, rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  err, err_owner
  );

endinterface

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between the icache (id 0) and dcache (id 1).
// One transaction at a time: IDLE (arbitrate, latch) -> BUSY (mem_req held) -> DONE (ack pulse).
// Ties are broken round-robin; a watchdog aborts a BUSY phase after TIMEOUT cycles without
// mem_ready, acking the owner with rdata=0 and raising the sticky err flag.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - mem_arbiter_if.master: requester handshakes, shared rdata, memory port, err status
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              ack_q, ack_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              err_owner_q, err_owner_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              gnt;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    ack_d       = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    err_owner_d = err_owner_q;
    cnt_d       = cnt_q;
    gnt         = RqI;

    case (state_q)
      StIdle: begin
        if (bus.i_req || bus.d_req) begin
          gnt         = rr_pick(bus.i_req, bus.d_req, last_q);
          owner_d     = gnt;
          mem_we_d    = (gnt == RqD) ? bus.d_we    : bus.i_we;
          mem_addr_d  = (gnt == RqD) ? bus.d_addr  : bus.i_addr;
          mem_wdata_d = (gnt == RqD) ? bus.d_wdata : bus.i_wdata;
          mem_req_d   = 1'b1;
          cnt_d       = '0;
          state_d     = StBusy;
        end
      end
      StBusy: begin
        if (bus.mem_ready) begin
          rdata_d   = bus.mem_rdata;
          ack_d     = 1'b1;
          last_d    = owner_q;
          mem_req_d = 1'b0;
          state_d   = StDone;
        end else if (cnt_q == CntLast) begin
          // Watchdog abort: this is the TIMEOUT-th BUSY cycle without a response.
          cnt_d       = CntMax;
          rdata_d     = '0;
          ack_d       = 1'b1;
          err_d       = 1'b1;
          err_owner_d = owner_q;
          mem_req_d   = 1'b0;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        // Requests seen here are not new ones; arbitration restarts in IDLE.
        mem_req_d = 1'b0;
        state_d   = StIdle;
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= RqI;
      last_q      <= RqD;  // icache wins the first tie
      ack_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      err_owner_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      ack_q       <= ack_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      err_owner_q <= err_owner_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.i_ack     = ack_q && (owner_q == RqI);
  assign bus.d_ack     = ack_q && (owner_q == RqD);
  assign bus.rdata     = rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.err       = err_q;
  assign bus.err_owner = err_owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (TIMEOUT=4): reset values, a vector table of single
// transactions, hand sequences for tie order, back-to-back spacing, watchdog abort and reset
// mid-transaction, then randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;

  localparam logic [31:0] K = 32'h5A5A_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        who;       // 0 icache, 1 dcache
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;     // BUSY cycle in which mem_ready is given
    logic [31:0] mem_data;
    logic [31:0] exp_rdata;
    int          exp_lat;   // cycles from req raise to ack, req cycle counted as 1
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic set_req(input logic who, input logic on, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (who == 1'b0) begin
      bus.i_req = on; bus.i_we = we; bus.i_addr = addr; bus.i_wdata = wdata;
    end else begin
      bus.d_req = on; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One transaction from IDLE with the memory answering in BUSY cycle v.delay.
  task automatic run_single(input vec_t v, input int idx);
    int   lat;
    int   busy;
    logic got;
    lat = 1; busy = 0; got = 1'b0;
    set_req(v.who, 1'b1, v.we, v.addr, v.wdata);
    while (!got && lat < 16) begin
      @(negedge clk);
      lat++;
      bus.mem_ready = 1'b0;
      if (bus.i_ack || bus.d_ack) begin
        got = 1'b1;
        chk($sformatf("vec%0d_owner", idx), 32'(bus.d_ack), 32'(v.who));
        chk($sformatf("vec%0d_ack_excl", idx), 32'(bus.i_ack & bus.d_ack), 32'h0);
        chk($sformatf("vec%0d_latency", idx), lat, v.exp_lat);
        chk($sformatf("vec%0d_rdata", idx), bus.rdata, v.exp_rdata);
        chk($sformatf("vec%0d_mem_req_low", idx), 32'(bus.mem_req), 32'h0);
      end else if (bus.mem_req) begin
        busy++;
        chk($sformatf("vec%0d_mem_addr", idx), bus.mem_addr, v.addr);
        chk($sformatf("vec%0d_mem_we", idx), 32'(bus.mem_we), 32'(v.we));
        chk($sformatf("vec%0d_mem_wdata", idx), bus.mem_wdata, v.wdata);
        if (busy == v.delay) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = v.mem_data;
        end
      end
    end
    if (!got) bound_fail($sformatf("vec%0d_ack", idx));
    set_req(v.who, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.mem_rdata = 32'h0;
    @(negedge clk);
  endtask

  // Both requesters held high; n acks expected, alternating from 'first'.
  task automatic run_both(input int n, input logic first, input string tag);
    logic        exp_who;
    logic        prev_req;
    int          acks, issued, cyc, last_ack;
    logic [31:0] ia, da;
    exp_who = first; ia = 32'h100; da = 32'h800;
    acks = 0; issued = 2; cyc = 0; last_ack = -1; prev_req = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, ia, 32'h0);
    set_req(1'b1, 1'b1, 1'b0, da, 32'h0);
    while (acks < n && cyc < 60) begin
      @(negedge clk);
      cyc++;
      bus.mem_ready = 1'b0;
      if (bus.i_ack || bus.d_ack) begin
        chk($sformatf("%s_order%0d", tag, acks), 32'(bus.d_ack), 32'(exp_who));
        chk($sformatf("%s_rdata%0d", tag, acks), bus.rdata, (exp_who ? da : ia) ^ K);
        if (last_ack >= 0) chk($sformatf("%s_gap%0d", tag, acks), cyc - last_ack, 3);
        last_ack = cyc;
        acks++;
        if (exp_who == 1'b0) begin
          ia = ia + 32'h4;
          if (issued < n) begin issued++; set_req(1'b0, 1'b1, 1'b0, ia, 32'h0); end
          else set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        end else begin
          da = da + 32'h4;
          if (issued < n) begin issued++; set_req(1'b1, 1'b1, 1'b0, da, 32'h0); end
          else set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        exp_who = ~exp_who;
      end else if (bus.mem_req && !prev_req) begin
        chk($sformatf("%s_addr%0d", tag, acks), bus.mem_addr, exp_who ? da : ia);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = (exp_who ? da : ia) ^ K;
      end
      prev_req = bus.mem_req;
    end
    if (acks < n) bound_fail($sformatf("%s_acks", tag));
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.mem_ready = 1'b0;
    @(negedge clk);
  endtask

  // Random-phase model state
  logic [1:0]  pend;
  logic [1:0]  req_prev;
  logic [31:0] r_addr  [2];
  logic [31:0] r_wdata [2];
  logic        r_we    [2];
  int          wait_c  [2];
  logic        m_last;
  logic        busy_on;
  logic        ready_given;
  logic        cur_owner;
  logic [31:0] cur_data;
  int          bcnt, bdelay, done_n;

  initial begin
    int   busy;
    logic got;
    logic own;

    tbl[0] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0,         2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4};
    tbl[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'h0000_1234, 3, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 5};
    tbl[2] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,         1, 32'h0BAD_F00D, 32'h0BAD_F00D, 3};
    tbl[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5};
    tbl[4] = '{1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 1, 32'h0,         32'h0,         3};
    tbl[5] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         2, 32'h1357_9BDF, 32'h1357_9BDF, 4};

    do_reset();
    chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_i_ack", 32'(bus.i_ack), 32'h0);
    chk("rst_d_ack", 32'(bus.d_ack), 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_err_owner", 32'(bus.err_owner), 32'h0);

    for (int i = 0; i < 6; i++) run_single(tbl[i], i);

    // Simultaneous requests from reset: icache first, dcache after one idle cycle.
    do_reset();
    run_both(2, 1'b0, "tie");
    // Four held transactions alternate I,D,I,D.
    run_both(4, 1'b0, "alt");

    // Watchdog: dcache read, memory never answers.
    set_req(1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
    busy = 0; got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      if (bus.d_ack) begin
        got = 1'b1;
        chk("to_busy_cycles", busy, 4);
        chk("to_rdata", bus.rdata, 32'h0);
        chk("to_err", 32'(bus.err), 32'h1);
        chk("to_err_owner", 32'(bus.err_owner), 32'h1);
        chk("to_mem_req", 32'(bus.mem_req), 32'h0);
        chk("to_i_ack", 32'(bus.i_ack), 32'h0);
      end else begin
        if (bus.mem_req) busy++;
        chk("to_err_early", 32'(bus.err), 32'h0);
      end
    end
    if (!got) bound_fail("to_ack");
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    run_single(tbl[0], 10);
    chk("to_err_sticky", 32'(bus.err), 32'h1);
    chk("to_err_owner_sticky", 32'(bus.err_owner), 32'h1);

    // Reset on the 2nd BUSY cycle of a dcache read (last served was icache).
    set_req(1'b1, 1'b1, 1'b0, 32'h500, 32'h0);
    busy = 0;
    for (int c = 0; c < 10 && busy < 2; c++) begin
      @(negedge clk);
      if (bus.mem_req) busy++;
    end
    if (busy < 2) bound_fail("mid_rst_busy");
    rst = 1'b1;
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("mid_rst_mem_req", 32'(bus.mem_req), 32'h0);
    chk("mid_rst_ack", 32'(bus.i_ack | bus.d_ack), 32'h0);
    chk("mid_rst_err", 32'(bus.err), 32'h0);
    chk("mid_rst_mem_addr", bus.mem_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ack", 32'(bus.i_ack | bus.d_ack), 32'h0);
    run_both(1, 1'b0, "post_rst_tie");

    // Randomized traffic against the transaction-level model.
    do_reset();
    pend = 2'b00; req_prev = 2'b00; m_last = 1'b1; busy_on = 1'b0; ready_given = 1'b0;
    cur_owner = 1'b0; cur_data = 32'h0; bcnt = 0; bdelay = 1; done_n = 0;
    wait_c[0] = 0; wait_c[1] = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      chk("rnd_i_ack", 32'(bus.i_ack), 32'(ready_given && cur_owner == 1'b0));
      chk("rnd_d_ack", 32'(bus.d_ack), 32'(ready_given && cur_owner == 1'b1));
      if (ready_given) begin
        chk("rnd_rdata", bus.rdata, cur_data);
        chk("rnd_ack_mem_req", 32'(bus.mem_req), 32'h0);
        chk("rnd_err", 32'(bus.err), 32'h0);
        pend[cur_owner] = 1'b0;
        m_last = cur_owner;
        done_n++;
        busy_on = 1'b0;
      end else if (bus.mem_req) begin
        if (!busy_on) begin
          // Grant decided on the requests presented during the preceding idle cycle.
          if (req_prev == 2'b00) bound_fail("rnd_spurious_grant");
          own = (req_prev == 2'b11) ? ~m_last : req_prev[1];
          cur_owner = own;
          busy_on = 1'b1;
          bcnt = 0;
          bdelay = int'($urandom_range(1, 3));
        end
        chk("rnd_mem_addr", bus.mem_addr, r_addr[cur_owner]);
        chk("rnd_mem_we", 32'(bus.mem_we), 32'(r_we[cur_owner]));
        chk("rnd_mem_wdata", bus.mem_wdata, r_wdata[cur_owner]);
        bcnt++;
      end
      ready_given = 1'b0;
      if (busy_on && bus.mem_req) begin
        bus.mem_rdata = $urandom;
        if (bcnt == bdelay) begin
          bus.mem_ready = 1'b1;
          cur_data = bus.mem_rdata;
          ready_given = 1'b1;
        end else begin
          bus.mem_ready = 1'b0;
        end
      end else begin
        // Responses outside BUSY must be ignored.
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
      end
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1'b1;
          r_addr[k] = $urandom & 32'hFFFF_FFFC;
          r_we[k] = (k == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
          r_wdata[k] = $urandom;
          wait_c[k] = 0;
        end
        if (pend[k]) begin
          wait_c[k]++;
          if (wait_c[k] == 40) bound_fail($sformatf("rnd_stall%0d", k));
        end
        set_req(1'(k), pend[k], r_we[k], r_addr[k], r_wdata[k]);
      end
      req_prev = pend;
    end
    chk("rnd_progress", 32'(done_n >= 100), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
